// File: rtl/tmr_error_ctrl.sv
// TMR error controller: filters voter mismatch flags, confirms faults,
// requests a resynchronisation of all harts and escalates to a latched
// fatal state when voting can no longer mask the fault.
module tmr_error_ctrl #(
    parameter int unsigned NHARTS         = 3,
    parameter int unsigned FILTER_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      tmr_enable_i,
    input  logic                      error_i,
    input  logic [NHARTS-1:0]         error_id_i,
    input  logic [NHARTS-1:0]         resync_done_i,
    input  logic                      clear_i,
    output logic [NHARTS-1:0]         resync_req_o,
    output logic [NHARTS-1:0]         faulty_hart_o,
    output logic [NHARTS*CNT_W-1:0]   err_cnt_o,
    output logic                      busy_o,
    output logic                      fatal_o
);

    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILTER,
        S_RESYNC,
        S_WAIT_ACK,
        S_FATAL
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [NHARTS-1:0]               r_pend;
    logic [NHARTS-1:0]               w_pend_nxt;
    logic [NHARTS-1:0]               r_ack;
    logic [NHARTS-1:0]               w_ack_nxt;
    logic [FW-1:0]                   r_filt;
    logic [FW-1:0]                   w_filt_nxt;
    logic [TW-1:0]                   r_tmo;
    logic [TW-1:0]                   w_tmo_nxt;
    logic [NHARTS-1:0][CNT_W-1:0]    r_cnt;
    logic [NHARTS-1:0][CNT_W-1:0]    w_cnt_nxt;
    logic [NHARTS-1:0]               r_faulty;
    logic [NHARTS-1:0]               w_faulty_nxt;
    logic [NHARTS-1:0]               r_resync_req;
    logic                            r_busy;
    logic                            r_fatal;
    logic [NHARTS-1:0]               w_pend_or;
    logic [NHARTS-1:0]               w_ack_or;
    logic                            w_wrap;

    function automatic int unsigned popcnt(input logic [NHARTS-1:0] x);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NHARTS; i++) begin
            if (x[i]) n++;
        end
        return n;
    endfunction

    assign w_pend_or = r_pend | error_id_i;
    assign w_ack_or  = r_ack | resync_done_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state and datapath next values; clear has priority over counter updates
    always_comb begin
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend;
        w_ack_nxt    = r_ack;
        w_filt_nxt   = r_filt;
        w_tmo_nxt    = r_tmo;
        w_cnt_nxt    = r_cnt;
        w_faulty_nxt = r_faulty;
        w_wrap       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (tmr_enable_i && error_i) begin
                    w_pend_nxt = error_id_i;
                    if (popcnt(error_id_i) >= 2) begin
                        w_state_nxt = S_FATAL;
                    end else if (FILTER_CYCLES == 1) begin
                        w_state_nxt = S_RESYNC;
                    end else begin
                        w_state_nxt = S_FILTER;
                        w_filt_nxt  = FW'(1);
                    end
                end
            end
            S_FILTER: begin
                if (!tmr_enable_i || !error_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pend_nxt = w_pend_or;
                    if (popcnt(w_pend_or) >= 2) begin
                        w_state_nxt = S_FATAL;
                    end else begin
                        w_filt_nxt = r_filt + FW'(1);
                        if (w_filt_nxt == FW'(FILTER_CYCLES)) w_state_nxt = S_RESYNC;
                    end
                end
            end
            S_RESYNC: begin
                for (int unsigned i = 0; i < NHARTS; i++) begin
                    if (r_pend[i]) begin
                        w_faulty_nxt[i] = 1'b1;
                        if (r_cnt[i] == '1) w_wrap = 1'b1;
                        else                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                w_ack_nxt   = '0;
                w_tmo_nxt   = '0;
                w_state_nxt = w_wrap ? S_FATAL : S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                w_ack_nxt = w_ack_or;
                w_tmo_nxt = r_tmo + TW'(1);
                if (w_ack_or == '1) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_FATAL;
                end
            end
            S_FATAL: begin
                if (clear_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear_i) begin
            w_cnt_nxt    = '0;
            w_faulty_nxt = '0;
        end
    end

    // Datapath and registered outputs, derived from the upcoming state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend       <= '0;
            r_ack        <= '0;
            r_filt       <= '0;
            r_tmo        <= '0;
            r_cnt        <= '0;
            r_faulty     <= '0;
            r_resync_req <= '0;
            r_busy       <= 1'b0;
            r_fatal      <= 1'b0;
        end else begin
            r_pend       <= w_pend_nxt;
            r_ack        <= w_ack_nxt;
            r_filt       <= w_filt_nxt;
            r_tmo        <= w_tmo_nxt;
            r_cnt        <= w_cnt_nxt;
            r_faulty     <= w_faulty_nxt;
            r_resync_req <= (w_state_nxt == S_WAIT_ACK) ? '1 : '0;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_fatal      <= (w_state_nxt == S_FATAL);
        end
    end

    assign resync_req_o  = r_resync_req;
    assign faulty_hart_o = r_faulty;
    assign err_cnt_o     = r_cnt;
    assign busy_o        = r_busy;
    assign fatal_o       = r_fatal;

endmodule
